pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 core.
- Owns the F pipeline register, which holds the predicted PC fed to fetch.
- Generates the stall and bubble controls for the F/D/E/M/W pipeline registers from hazard conditions: load-use, ret in flight, jXX mispredict, exceptions.
- Runs a run/stop state machine and keeps saturating performance counters.

Parameters:
- RESET_PC, 64'h0, value loaded into F_pred_pc_o on reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_pred_pc_i  in  64  next predicted PC from fetch.
- D_icode_i  in  4  icode held in D register.
- E_icode_i  in  4  icode held in E register.
- M_icode_i  in  4  icode held in M register.
- W_icode_i  in  4  icode held in W register.
- E_dstM_i  in  4  dstM held in E register.
- d_srcA_i  in  4  srcA decoded in D stage.
- d_srcB_i  in  4  srcB decoded in D stage.
- e_Cnd_i  in  1  condition outcome from execute.
- m_stat_i  in  4  status produced in memory stage.
- W_stat_i  in  4  status held in W register.
- F_pred_pc_o  out  64  registered predicted PC.
- F_stall_o  out  1  hold F register.
- D_stall_o  out  1  hold D register.
- D_bubble_o  out  1  load nop into D.
- E_bubble_o  out  1  load nop into E.
- M_bubble_o  out  1  load nop into M.
- W_stall_o  out  1  hold W register.
- set_cc_o  out  1  condition codes may update.
- running_o  out  1  1 in RUN, 0 in STOP.
- final_stat_o  out  4  status that caused STOP; SAOK while running.
- cycle_cnt_o  out  CNT_W  cycles spent in RUN.
- instr_cnt_o  out  CNT_W  retired instructions.
- stall_cnt_o  out  CNT_W  RUN cycles with F_stall_o=1.
- mispred_cnt_o  out  CNT_W  jXX mispredicts.

Behaviour:
- Encodings: IHALT=0, INOP=1, IOPQ=6, IJXX=7, IRET=9, IMRMOVQ=5, IPOPQ=B; RNONE=F; SAOK=1, SHLT=2, SADR=3, SINS=4.
- Combinational hazard terms:
  - load_use = (E_icode in {IMRMOVQ, IPOPQ}) && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
  - ret_pend = IRET in {D_icode, E_icode, M_icode}.
  - mispred = E_icode==IJXX && !e_Cnd.
  - exc_m = m_stat!=SAOK.
  - exc_w = W_stat!=SAOK.
- Control outputs in RUN (combinational, zero latency):
  - F_stall = load_use | ret_pend.
  - D_stall = load_use.
  - D_bubble = mispred | (ret_pend & !load_use).
  - E_bubble = mispred | load_use.
  - M_bubble = exc_m | exc_w.
  - W_stall = exc_w.
  - set_cc = E_icode==IOPQ & !exc_m & !exc_w.
- D_stall and D_bubble are never both 1. Mispredict plus ret_pend in the same cycle yields D_bubble=1, E_bubble=1, F_stall=1.
- State machine, states RUN and STOP:
  - rst forces RUN and final_stat=SAOK.
  - RUN -> STOP on the edge where exc_w=1; final_stat latches W_stat_i on that edge.
  - STOP is sticky until rst.
- In STOP, outputs are forced:
  - F_stall=D_stall=W_stall=1.
  - All bubbles = 0.
  - set_cc = 0.
- F register:
  - rst loads RESET_PC asynchronously.
  - Each edge: if running and !F_stall, load f_pred_pc_i; otherwise hold.
- Counters:
  - All counters clear on rst and saturate at all-ones (no wrap).
  - cycle_cnt increments every RUN cycle.
  - stall_cnt increments on RUN cycles with F_stall=1.
  - mispred_cnt increments on RUN cycles with mispred=1.
  - instr_cnt increments on RUN cycles with W_stat==SAOK and W_icode!=INOP.
- Reset mid-operation: asynchronous; all registers return to reset values immediately, regardless of state.
- Reset values of outputs:
  - F_pred_pc_o = RESET_PC.
  - running_o = 1.
  - final_stat_o = SAOK.
  - All counters = 0.
  - Control outputs follow the combinational rules above.

Test Plan:
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; F_pred_pc_o held at 0x40 for one cycle while f_pred_pc_i=0x4A; stall_cnt +1.
- Ret: D_icode=9 for one cycle, then E, then M -> three cycles with F_stall=1 and D_bubble=1; F_pred_pc_o unchanged for those cycles.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; mispred_cnt goes 0->1. Repeat with e_Cnd=1 -> no bubbles.
- Exception/halt: m_stat=SADR -> M_bubble=1, set_cc=0 with E_icode=6. Next cycle W_stat=SHLT -> W_stall=1; after the edge running_o=0, final_stat_o=2, cycle_cnt frozen, F_pred_pc_o frozen.
- Reset mid-run: assert rst asynchronously mid-cycle with counters at 17 -> counters 0, F_pred_pc_o=RESET_PC, running_o=1, all without waiting for a clock edge.
- Saturation: CNT_W=4, 20 RUN cycles -> cycle_cnt_o stays at 15 (no wrap).

Source files
------------

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble generation,
// F register (predicted PC), run/stop FSM and perf counters.
module pipe_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      f_pred_pc_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       W_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic             e_Cnd_i,
  input  logic [3:0]       m_stat_i,
  input  logic [3:0]       W_stat_i,
  output logic [63:0]      F_pred_pc_o,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic             set_cc_o,
  output logic             running_o,
  output logic [3:0]       final_stat_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] SAOK    = 4'h1;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {RUN = 1'b0, STOP = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [3:0]       fstat_q, fstat_d;
  logic [63:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;
  logic [CNT_W-1:0] stl_q, stl_d;
  logic [CNT_W-1:0] mis_q, mis_d;

  logic load_use, ret_pend, mispred, exc_m, exc_w;
  logic run, f_stall_run;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + ONE : v;
  endfunction

  // Hazard detection terms
  always_comb begin
    load_use = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ))
             && (E_dstM_i != RNONE)
             && ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    ret_pend = (D_icode_i == IRET) || (E_icode_i == IRET)
             || (M_icode_i == IRET);
    mispred  = (E_icode_i == IJXX) && !e_Cnd_i;
    exc_m    = (m_stat_i != SAOK);
    exc_w    = (W_stat_i != SAOK);
    run      = (state_q == RUN);
    f_stall_run = load_use | ret_pend;
  end

  // Next state, control outputs and register next values
  always_comb begin
    state_d    = state_q;
    fstat_d    = fstat_q;
    F_stall_o  = 1'b1;
    D_stall_o  = 1'b1;
    W_stall_o  = 1'b1;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    set_cc_o   = 1'b0;
    if (run) begin
      F_stall_o  = f_stall_run;
      D_stall_o  = load_use;
      D_bubble_o = mispred | (ret_pend & !load_use);
      E_bubble_o = mispred | load_use;
      M_bubble_o = exc_m | exc_w;
      W_stall_o  = exc_w;
      set_cc_o   = (E_icode_i == IOPQ) & !exc_m & !exc_w;
      if (exc_w) begin
        state_d = STOP;
        fstat_d = W_stat_i;
      end
    end
    pc_d  = (run && !f_stall_run) ? f_pred_pc_i : pc_q;
    cyc_d = sat_inc(cyc_q, run);
    stl_d = sat_inc(stl_q, run && f_stall_run);
    mis_d = sat_inc(mis_q, run && mispred);
    ins_d = sat_inc(ins_q, run && !exc_w && (W_icode_i != INOP));
  end

  // State, F register and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fstat_q <= SAOK;
      pc_q    <= RESET_PC;
      cyc_q   <= '0;
      ins_q   <= '0;
      stl_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      fstat_q <= fstat_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      stl_q   <= stl_d;
      mis_q   <= mis_d;
    end
  end

  assign F_pred_pc_o   = pc_q;
  assign running_o     = run;
  assign final_stat_o  = fstat_q;
  assign cycle_cnt_o   = cyc_q;
  assign instr_cnt_o   = ins_q;
  assign stall_cnt_o   = stl_q;
  assign mispred_cnt_o = mis_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, halt, async reset,
// and counter saturation on a narrow-counter instance.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] f_pc;
  logic [3:0]  D_ic, E_ic, M_ic, W_ic, E_dstM, srcA, srcB;
  logic        cnd;
  logic [3:0]  m_st, W_st;

  logic [63:0] pc1, pc2;
  logic        fs1, ds1, db1, eb1, mb1, ws1, cc1, run1;
  logic        fs2, ds2, db2, eb2, mb2, ws2, cc2, run2;
  logic [3:0]  st1, st2;
  logic [31:0] cyc1, ins1, stl1, mis1;
  logic [3:0]  cyc2, ins2, stl2, mis2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .f_pred_pc_i(f_pc),
    .D_icode_i(D_ic), .E_icode_i(E_ic),
    .M_icode_i(M_ic), .W_icode_i(W_ic),
    .E_dstM_i(E_dstM), .d_srcA_i(srcA), .d_srcB_i(srcB),
    .e_Cnd_i(cnd), .m_stat_i(m_st), .W_stat_i(W_st),
    .F_pred_pc_o(pc1), .F_stall_o(fs1), .D_stall_o(ds1),
    .D_bubble_o(db1), .E_bubble_o(eb1), .M_bubble_o(mb1),
    .W_stall_o(ws1), .set_cc_o(cc1), .running_o(run1),
    .final_stat_o(st1), .cycle_cnt_o(cyc1),
    .instr_cnt_o(ins1), .stall_cnt_o(stl1),
    .mispred_cnt_o(mis1)
  );

  pipe_ctrl #(.RESET_PC(64'h0), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .f_pred_pc_i(f_pc),
    .D_icode_i(D_ic), .E_icode_i(E_ic),
    .M_icode_i(M_ic), .W_icode_i(W_ic),
    .E_dstM_i(E_dstM), .d_srcA_i(srcA), .d_srcB_i(srcB),
    .e_Cnd_i(cnd), .m_stat_i(m_st), .W_stat_i(W_st),
    .F_pred_pc_o(pc2), .F_stall_o(fs2), .D_stall_o(ds2),
    .D_bubble_o(db2), .E_bubble_o(eb2), .M_bubble_o(mb2),
    .W_stall_o(ws2), .set_cc_o(cc2), .running_o(run2),
    .final_stat_o(st2), .cycle_cnt_o(cyc2),
    .instr_cnt_o(ins2), .stall_cnt_o(stl2),
    .mispred_cnt_o(mis2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_ic = 4'h1; E_ic = 4'h1; M_ic = 4'h1; W_ic = 4'h1;
    E_dstM = 4'hF; srcA = 4'hF; srcB = 4'hF;
    cnd = 1'b1; m_st = 4'h1; W_st = 4'h1;
  endtask

  task automatic ctl(input string tag,
                     input logic [6:0] exp);
    #1;
    chk(tag, {fs1, ds1, db1, eb1, mb1, ws1, cc1}, exp);
  endtask

  initial begin
    idle();
    f_pc = 64'h0;
    #1 rst = 1'b1;
    #1;
    chk("rst_pc", pc1, 64'h0);
    chk("rst_run", run1, 1'b1);
    chk("rst_stat", st1, 4'h1);
    chk("rst_cnt", {cyc1, ins1, stl1, mis1}, 0);
    ctl("rst_ctl", 7'b0000000);
    @(negedge clk) rst = 1'b0;

    f_pc = 64'h40;
    tick();
    chk("pc_load", pc1, 64'h40);
    chk("cyc_1", cyc1, 1);

    // load-use
    E_ic = 4'h5; E_dstM = 4'h3; srcA = 4'h3; f_pc = 64'h4A;
    ctl("lu_ctl", 7'b1101000);
    tick();
    chk("lu_pc_hold", pc1, 64'h40);
    chk("lu_stl", stl1, 1);
    idle();
    tick();
    chk("lu_pc_go", pc1, 64'h4A);

    // ret through D, E, M
    f_pc = 64'h50;
    D_ic = 4'h9;
    ctl("ret_d", 7'b1010000);
    tick();
    D_ic = 4'h1; E_ic = 4'h9;
    ctl("ret_e", 7'b1010000);
    tick();
    E_ic = 4'h1; M_ic = 4'h9;
    ctl("ret_m", 7'b1010000);
    tick();
    chk("ret_pc_hold", pc1, 64'h4A);
    chk("ret_stl", stl1, 4);
    M_ic = 4'h1;
    tick();
    chk("ret_pc_go", pc1, 64'h50);
    chk("cyc_7", cyc1, 7);

    // mispredict
    E_ic = 4'h7; cnd = 1'b0;
    ctl("mp_ctl", 7'b0011000);
    chk("mp_cnt0", mis1, 0);
    tick();
    chk("mp_cnt1", mis1, 1);
    cnd = 1'b1;
    ctl("tk_ctl", 7'b0000000);
    tick();
    chk("tk_cnt", mis1, 1);
    cnd = 1'b0; D_ic = 4'h9;
    ctl("mp_ret", 7'b1011000);
    idle();

    // retire one instruction
    W_ic = 4'h6;
    tick();
    chk("ins_1", ins1, 1);
    W_ic = 4'h1;

    // exception then halt
    E_ic = 4'h6;
    ctl("cc_ok", 7'b0000001);
    m_st = 4'h3;
    ctl("exc_m", 7'b0000100);
    tick();
    m_st = 4'h1; W_st = 4'h2; W_ic = 4'h0; f_pc = 64'h60;
    ctl("exc_w", 7'b0000110);
    chk("run_pre", run1, 1'b1);
    tick();
    chk("halt_run", run1, 1'b0);
    chk("halt_stat", st1, 4'h2);
    chk("halt_cyc", cyc1, 12);
    chk("halt_pc", pc1, 64'h60);
    chk("halt_ins", ins1, 1);
    W_st = 4'h1; f_pc = 64'h70; E_ic = 4'h7; cnd = 1'b0;
    ctl("stop_ctl", 7'b1100010);
    tick();
    tick();
    chk("stop_cyc", cyc1, 12);
    chk("stop_pc", pc1, 64'h60);
    chk("stop_stat", st1, 4'h2);
    chk("stop_mis", mis1, 1);

    // restart, run 17 cycles, reset mid-cycle
    rst = 1'b1;
    #1;
    chk("rst2_run", run1, 1'b1);
    chk("rst2_stat", st1, 4'h1);
    @(negedge clk) rst = 1'b0;
    idle();
    E_ic = 4'h7; cnd = 1'b0; W_ic = 4'h6; f_pc = 64'h88;
    for (int i = 0; i < 17; i++) tick();
    chk("c17_cyc", cyc1, 17);
    chk("c17_ins", ins1, 17);
    chk("c17_mis", mis1, 17);
    chk("c17_stl", stl1, 0);
    chk("c17_pc", pc1, 64'h88);
    chk("sat_cyc17", cyc2, 4'hF);
    chk("sat_mis17", mis2, 4'hF);
    #3 rst = 1'b1;
    #1;
    chk("arst_cnt", {cyc1, ins1, stl1, mis1}, 0);
    chk("arst_pc", pc1, 64'h0);
    chk("arst_run", run1, 1'b1);
    chk("arst_cnt4", {cyc2, ins2, mis2}, 0);

    // saturation over 20 cycles
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("sat_cyc15", cyc2, 4'hF);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_cyc20", cyc2, 4'hF);
    chk("sat_ins20", ins2, 4'hF);
    chk("wide_cyc20", cyc1, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
